// File: rtl/uart_tx_if.sv
// Byte-in handshake and serial-out bundle between a producer and uart_tx.
interface uart_tx_if;
   logic [7:0] i_data;
   logic       i_start;
   logic       o_ready;
   logic       o_done;
   logic       tx;

   // Producer side: drives the byte request, observes status and line
   modport master (
      output i_data,
      output i_start,
      input  o_ready,
      input  o_done,
      input  tx
   );

   // Transmitter side
   modport slave (
      input  i_data,
      input  i_start,
      output o_ready,
      output o_done,
      output tx
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// internal baud counter. All outputs are registered from the next state so
// they change on the same edge as the state they describe.
module uart_tx #(
   parameter int unsigned BAUD      = 104,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   localparam int unsigned      CNT_W     = (BAUD > 1) ? $clog2(BAUD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [2:0]       bit_q, bit_n;
   logic [7:0]       shreg_q, shreg_n;
   logic             par_q, par_n;
   logic             tx_q, tx_n;
   logic             ready_q, ready_n;
   logic             done_q, done_n;
   logic             accept_c;
   logic             bit_end_c;

   assign accept_c  = bus.i_start && ready_q;
   assign bit_end_c = (cnt_q == CNT_LAST);

   // Next-state, datapath and registered-output values
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q + CNT_W'(1);
      bit_n   = bit_q;
      shreg_n = shreg_q;
      par_n   = par_q;

      case (state_q)
         S_IDLE: begin
            cnt_n = '0;
            bit_n = '0;
            if (accept_c) begin
               state_n = S_START;
               shreg_n = bus.i_data;
               par_n   = (^bus.i_data) ^ (PARITY == 2);
            end
         end
         S_START: begin
            if (bit_end_c) begin
               cnt_n   = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end_c) begin
               cnt_n   = '0;
               shreg_n = {1'b0, shreg_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_n   = '0;
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end_c) begin
               cnt_n   = '0;
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end_c) begin
               cnt_n = '0;
               if (bit_q == STOP_LAST) begin
                  bit_n   = '0;
                  state_n = S_IDLE;
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end
         end
         default: begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = S_IDLE;
         end
      endcase

      case (state_n)
         S_START:  tx_n = 1'b0;
         S_DATA:   tx_n = shreg_n[0];
         S_PARITY: tx_n = par_n;
         default:  tx_n = 1'b1;
      endcase

      ready_n = (state_n == S_IDLE);
      done_n  = (state_q == S_STOP) && (state_n == S_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
         par_q   <= par_n;
         tx_q    <= tx_n;
         ready_q <= ready_n;
         done_q  <= done_n;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.o_ready = ready_q;
   assign bus.o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances cover no/even/odd parity
// and one/two stop bits at BAUD=4, checked against a slot-based frame model.
module tb_uart_tx;

   localparam int B = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] st;
   logic [7:0] dat [3];
   logic [2:0] txv, rdy, dn;

   int checks   = 0;
   int failures = 0;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();

   assign if0.i_start = st[0];
   assign if1.i_start = st[1];
   assign if2.i_start = st[2];
   assign if0.i_data  = dat[0];
   assign if1.i_data  = dat[1];
   assign if2.i_data  = dat[2];
   assign txv = {if2.tx, if1.tx, if0.tx};
   assign rdy = {if2.o_ready, if1.o_ready, if0.o_ready};
   assign dn  = {if2.o_done, if1.o_done, if0.o_done};

   uart_tx #(.BAUD(B), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   uart_tx #(.BAUD(B), .PARITY(1), .STOP_BITS(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   uart_tx #(.BAUD(B), .PARITY(2), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   // Free-running clock
   always #5 clk = ~clk;

   function automatic int par_of(input int sel);
      case (sel)
         1:       return 1;
         2:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int stops_of(input int sel);
      return (sel == 0) ? 1 : 2;
   endfunction

   function automatic int frame_len(input int sel);
      return B * (9 + ((par_of(sel) != 0) ? 1 : 0) + stops_of(sel));
   endfunction

   // Expected line level t cycles after the accept edge (t = 1..F)
   function automatic logic exp_tx(input int sel, input logic [7:0] b, input int t);
      int slot;
      slot = (t - 1) / B;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[3'(slot - 1)];
      if (par_of(sel) != 0 && slot == 9) return (^b) ^ (par_of(sel) == 2);
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns just after the accept edge
   task automatic start_frame(input int sel, input logic [7:0] b);
      st[sel]  = 1'b1;
      dat[sel] = b;
      tick();
      st[sel]  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      st  = 3'b111;
      for (int i = 0; i < 3; i++) begin
         dat[i] = 8'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({txv, rdy, dn} !== 9'b111_111_000) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got tx=%b rdy=%b done=%b exp tx=111 rdy=111 done=000",
                     i, txv, rdy, dn);
         end
      end
      rst = 1'b0;
      st  = 3'b000;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({txv, rdy, dn} !== 9'b111_111_000) begin
            failures++;
            $display("FAIL reset_release cyc=%0d got tx=%b rdy=%b done=%b exp tx=111 rdy=111 done=000",
                     i, txv, rdy, dn);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] b;
      logic [9:0] slots;
      int         f;
      b     = 8'hA5;
      slots = 10'b1101001010;
      f     = frame_len(0);
      start_frame(0, b);
      for (int t = 1; t <= f; t++) begin
         checks++;
         if (txv[0] !== slots[(t - 1) / B]) begin
            failures++;
            $display("FAIL basic_tx t=%0d got=%b exp=%b", t, txv[0], slots[(t - 1) / B]);
         end
         checks++;
         if ({rdy[0], dn[0]} !== 2'b00) begin
            failures++;
            $display("FAIL basic_busy t=%0d got rdy=%b done=%b exp rdy=0 done=0", t, rdy[0], dn[0]);
         end
         tick();
      end
      checks++;
      if ({txv[0], rdy[0], dn[0]} !== 3'b111) begin
         failures++;
         $display("FAIL basic_done t=%0d got tx=%b rdy=%b done=%b exp 1 1 1", f + 1, txv[0], rdy[0], dn[0]);
      end
      tick();
      checks++;
      if ({txv[0], rdy[0], dn[0]} !== 3'b110) begin
         failures++;
         $display("FAIL basic_done_width got tx=%b rdy=%b done=%b exp 1 1 0", txv[0], rdy[0], dn[0]);
      end
   endtask

   task automatic test_parity_stop();
      logic [7:0] b;
      logic       par_exp;
      int         f, low;
      b = 8'h07;
      for (int sel = 1; sel <= 2; sel++) begin
         f       = frame_len(sel);
         par_exp = (sel == 1) ? 1'b1 : 1'b0;
         low     = 0;
         start_frame(sel, b);
         for (int t = 1; t <= f; t++) begin
            if (rdy[sel] === 1'b0) low++;
            checks++;
            if (txv[sel] !== exp_tx(sel, b, t)) begin
               failures++;
               $display("FAIL par_tx sel=%0d t=%0d got=%b exp=%b", sel, t, txv[sel], exp_tx(sel, b, t));
            end
            if ((t - 1) / B == 9) begin
               checks++;
               if (txv[sel] !== par_exp) begin
                  failures++;
                  $display("FAIL par_bit sel=%0d t=%0d got=%b exp=%b", sel, t, txv[sel], par_exp);
               end
            end
            if ((t - 1) / B >= 10) begin
               checks++;
               if ({txv[sel], dn[sel]} !== 2'b10) begin
                  failures++;
                  $display("FAIL par_stop sel=%0d t=%0d got tx=%b done=%b exp tx=1 done=0", sel, t, txv[sel], dn[sel]);
               end
            end
            tick();
         end
         checks++;
         if (low !== 48) begin
            failures++;
            $display("FAIL par_ready_low sel=%0d got=%0d exp=48", sel, low);
         end
         checks++;
         if ({txv[sel], rdy[sel], dn[sel]} !== 3'b111) begin
            failures++;
            $display("FAIL par_done sel=%0d got tx=%b rdy=%b done=%b exp 1 1 1", sel, txv[sel], rdy[sel], dn[sel]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic       q [$];
      logic [7:0] got [$];
      logic [7:0] bytes [2];
      logic [7:0] v;
      int         f, i, run;
      bytes[0] = 8'hFF;
      bytes[1] = 8'h00;
      f        = frame_len(0);
      start_frame(0, bytes[0]);
      for (int n = 0; n < 2; n++) begin
         for (int t = 1; t <= f; t++) begin
            q.push_back(txv[0]);
            checks++;
            if (txv[0] !== exp_tx(0, bytes[n], t)) begin
               failures++;
               $display("FAIL b2b_tx frame=%0d t=%0d got=%b exp=%b", n, t, txv[0], exp_tx(0, bytes[n], t));
            end
            tick();
         end
         q.push_back(txv[0]);
         checks++;
         if ({rdy[0], dn[0]} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_done frame=%0d got rdy=%b done=%b exp 1 1", n, rdy[0], dn[0]);
         end
         if (n == 0) start_frame(0, bytes[1]);
         else tick();
      end
      for (int k = 0; k < 6; k++) begin
         q.push_back(txv[0]);
         tick();
      end
      // Independent line decoder sampling mid-bit
      i = 0;
      while (i < q.size()) begin
         if (q[i] == 1'b0 && i + B * 10 <= q.size()) begin
            for (int k = 0; k < 8; k++) v[k] = q[i + B / 2 + B * (k + 1)];
            got.push_back(v);
            i += B * 10;
         end else begin
            i++;
         end
      end
      checks++;
      if (got.size() !== 2) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=2", got.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== bytes[k]) begin
               failures++;
               $display("FAIL b2b_decode idx=%0d got=%h exp=%h", k, got[k], bytes[k]);
            end
         end
      end
      run = 0;
      for (int k = B * 9; k < q.size() && q[k] == 1'b1; k++) run++;
      checks++;
      if (run !== B + 1) begin
         failures++;
         $display("FAIL b2b_gap got=%0d exp=%0d", run, B + 1);
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] b;
      int         f, dones;
      b     = 8'h81;
      f     = frame_len(0);
      dones = 0;
      start_frame(0, b);
      dat[0] = 8'h3C;
      for (int t = 1; t <= f + 20; t++) begin
         if (dn[0] === 1'b1) dones++;
         checks++;
         if (t <= f) begin
            if (txv[0] !== exp_tx(0, b, t)) begin
               failures++;
               $display("FAIL busy_tx t=%0d got=%b exp=%b", t, txv[0], exp_tx(0, b, t));
            end
         end else if ({txv[0], rdy[0]} !== 2'b11) begin
            failures++;
            $display("FAIL busy_idle t=%0d got tx=%b rdy=%b exp 1 1", t, txv[0], rdy[0]);
         end
         st[0] = (t == 12);
         tick();
      end
      checks++;
      if (dones !== 1) begin
         failures++;
         $display("FAIL busy_done_count got=%0d exp=1", dones);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] b;
      int         f;
      f = frame_len(0);
      b = 8'($urandom);
      start_frame(0, b);
      for (int t = 1; t <= 18; t++) begin
         checks++;
         if (txv[0] !== exp_tx(0, b, t)) begin
            failures++;
            $display("FAIL midrst_pre t=%0d got=%b exp=%b", t, txv[0], exp_tx(0, b, t));
         end
         if (t == 18) rst = 1'b1;
         tick();
      end
      rst = 1'b0;
      checks++;
      if ({txv, rdy, dn} !== 9'b111_111_000) begin
         failures++;
         $display("FAIL midrst_abort got tx=%b rdy=%b done=%b exp tx=111 rdy=111 done=000", txv, rdy, dn);
      end
      for (int t = 0; t < f + 5; t++) begin
         tick();
         checks++;
         if ({txv[0], dn[0]} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_quiet t=%0d got tx=%b done=%b exp tx=1 done=0", t, txv[0], dn[0]);
         end
      end
      b = 8'h55;
      start_frame(0, b);
      for (int t = 1; t <= f; t++) begin
         checks++;
         if (txv[0] !== exp_tx(0, b, t)) begin
            failures++;
            $display("FAIL midrst_new t=%0d got=%b exp=%b", t, txv[0], exp_tx(0, b, t));
         end
         tick();
      end
      checks++;
      if ({rdy[0], dn[0]} !== 2'b11) begin
         failures++;
         $display("FAIL midrst_new_done got rdy=%b done=%b exp 1 1", rdy[0], dn[0]);
      end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         sel, f, gap;
      for (int n = 0; n < 12; n++) begin
         sel = int'($urandom_range(0, 2));
         b   = 8'($urandom);
         gap = int'($urandom_range(0, 3));
         f   = frame_len(sel);
         for (int g = 0; g < gap; g++) tick();
         start_frame(sel, b);
         dat[sel] = 8'($urandom);
         for (int t = 1; t <= f; t++) begin
            checks++;
            if ({txv[sel], rdy[sel], dn[sel]} !== {exp_tx(sel, b, t), 2'b00}) begin
               failures++;
               $display("FAIL rand_frame n=%0d sel=%0d byte=%h t=%0d got tx=%b rdy=%b done=%b exp tx=%b rdy=0 done=0",
                        n, sel, b, t, txv[sel], rdy[sel], dn[sel], exp_tx(sel, b, t));
            end
            tick();
         end
         checks++;
         if ({txv[sel], rdy[sel], dn[sel]} !== 3'b111) begin
            failures++;
            $display("FAIL rand_done n=%0d sel=%0d got tx=%b rdy=%b done=%b exp 1 1 1",
                     n, sel, txv[sel], rdy[sel], dn[sel]);
         end
      end
      tick();
   endtask

   // Scenario sequence
   initial begin
      rst = 1'b1;
      st  = 3'b000;
      for (int i = 0; i < 3; i++) dat[i] = 8'h00;
      test_reset();
      test_basic();
      test_parity_stop();
      test_back_to_back();
      test_busy_ignore();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a byte over a single-cycle valid/ready handshake and serialises it on `tx` as an 8-bit, LSB-first frame: one start bit, an optional parity bit, and one or two stop bits. Bit timing comes from an internal baud counter, so no external pulse generator is needed. It sits between the system-side producer (loopback logic, command engine) and the FPGA's UART TX pin.

## Interface
- `BAUD`, 104: clk cycles per bit (104 gives 115200 baud at 12 MHz); legal range 2..65535.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_data` input 8: byte to send; sampled only on accept.
- `i_start` input 1: request to send `i_data`.
- `o_ready` output 1: high when a request will be accepted this cycle.
- `o_done` output 1: one-cycle pulse when a frame's last stop bit completes.
- `tx` output 1: serial line, idle high, registered.

## Operation
- Reset values: `tx`=1, `o_ready`=1, `o_done`=0, state IDLE, baud counter 0, shift register 0.
- Accept means `i_start`=1 and `o_ready`=1 at a rising edge. On accept, `i_data` is latched and the baud counter is cleared. Later changes to `i_data` have no effect on the frame.
- `i_start` while `o_ready`=0 is ignored. It is not queued.
- Parity is computed from the latched byte: even means XOR of the data bits; odd means the inverted XOR.
- States:
  - IDLE: `tx`=1, `o_ready`=1. On accept, go to START.
  - START: `tx`=0 for BAUD cycles, then DATA.
  - DATA: bits 0..7 LSB first, BAUD cycles each, with a 3-bit bit index. After bit 7, go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: `tx`=parity bit for BAUD cycles, then STOP.
  - STOP: `tx`=1 for BAUD×`STOP_BITS` cycles, then IDLE.
- Baud counter: width ceil(log2(BAUD)). It counts 0..BAUD-1, and the bit advances on terminal count (BAUD-1). It wraps to 0 at every bit boundary and is held at 0 in IDLE.
- `o_done` is registered. It is high for exactly one cycle: the first IDLE cycle after STOP. `o_ready` is high in that same cycle.
- Back-to-back: an accept in the `o_done` cycle starts the next start bit on the following edge, with no extra idle bit.
- `rst` mid-frame: the frame is abandoned. On the next edge `tx`=1, `o_ready`=1, `o_done`=0, and no `o_done` pulse is generated for the aborted frame.
- `rst` together with `i_start`: reset wins and nothing is accepted.

## Timing
- Accept at edge N: `tx` falls and `o_ready` falls on edge N+1 (1-cycle latency).
- Frame length F = BAUD×(1+8+P+STOP_BITS), where P=1 if `PARITY`≠0, else 0.
- Data bit k occupies cycles N+1+BAUD×(1+k) to N+BAUD×(2+k), inclusive.
- `o_ready` is low for exactly F cycles; it and `o_done` rise at edge N+1+F.
- Maximum throughput is one byte every F+1 cycles (the accept cycle is the idle gap).
- `tx` is glitch-free: it changes only on a bit boundary.

## Test plan
- Reset: hold `rst` 3 cycles with `i_start`=1 → `tx`=1, `o_ready`=1, `o_done`=0 throughout, and no frame after release.
- Basic frame: BAUD=4, PARITY=0, STOP_BITS=1; send 0xA5 → `tx` sequence (4 cycles each) is 0,1,0,1,0,0,1,0,1,1; `o_ready` low for 40 cycles; `o_done` pulses at accept+41.
- Parity and stop bits:
  - BAUD=4, PARITY=1, STOP_BITS=2; send 0x07 → parity bit 1, stop held 8 cycles, F=48.
  - PARITY=2 with 0x07 → parity bit 0.
- Back-to-back: assert `i_start` in the `o_done` cycle with 0x00 after 0xFF → second start bit begins the next cycle, no extra high bit between frames; receiver model decodes 0xFF then 0x00.
- Busy ignore and data hold: pulse `i_start` with 0x3C mid-frame, and change `i_data` after accept of 0x81 → only 0x81 is transmitted, and `o_done` pulses once.
- Mid-frame reset: assert `rst` during data bit 3 → `tx`=1 next cycle, no `o_done`; a new frame of 0x55 after release is correct bit-for-bit.
